// File: rtl/smg_multi_digit_display.sv
// rtl/smg_multi_digit_display.sv - binary-to-BCD converter with multiplexed 7-segment scan
module smg_multi_digit_display #(
    parameter int DIGITS      = 6,
    parameter int DATA_W      = 20,
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        Row_Scan_Sig,
    output logic [DIGITS-1:0] Column_Scan_Sig
);

    // ceil(DATA_W*log10(2)) + 1 nibbles, kept at least one nibble above the display
    localparam int NIB_CALC = (DATA_W * 30103 + 99999) / 100000 + 1;
    localparam int NIB      = (NIB_CALC > DIGITS) ? NIB_CALC : DIGITS + 1;
    localparam int CNT_W    = $clog2(DATA_W + 1);
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0]        ROW_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] COL_OFF = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DATA_W-1:0]      bin_sr;
    logic [NIB*4-1:0]       bcd;
    logic [NIB*4-1:0]       bcd_adj;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DIGITS*4-1:0]    disp;
    logic [SCAN_W-1:0]      scan_cnt;
    logic [IDX_W-1:0]       idx;
    logic [3:0]             cur_nib;
    logic                   upper_zero;
    logic [7:0]             seg;
    logic [DIGITS-1:0]      sel;

    assign busy = (state != IDLE);

    // converter state register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // converter next-state: DATA_W shift cycles then a single commit cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(DATA_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // double-dabble correction: every nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NIB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // conversion datapath and atomic display-buffer commit
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            bin_sr   <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr  <= data_in;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    bcd     <= {bcd_adj[NIB*4-2:0], bin_sr[DATA_W-1]};
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                COMMIT: begin
                    disp     <= bcd[DIGITS*4-1:0];
                    overflow <= |bcd[NIB*4-1:DIGITS*4];
                end
                default: ;
            endcase
        end
    end

    // scan prescaler and digit index, free-running independent of the converter
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (idx == IDX_W'(DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // digit content for the current index: dash on overflow, leading-zero blanking, else decimal
    always_comb begin
        cur_nib    = 4'd0;
        upper_zero = 1'b1;
        sel        = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == int'(idx)) begin
                cur_nib = disp[4*k +: 4];
                sel[k]  = 1'b1;
            end
            if (k >= int'(idx) && disp[4*k +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        case (cur_nib)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h00;
        endcase
        if (overflow) begin
            seg = 8'h40;
        end else if (blank_lz && idx != '0 && upper_zero) begin
            seg = 8'h00;
        end
    end

    // segment and select lines registered together so they always agree
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Row_Scan_Sig    <= ROW_OFF;
            Column_Scan_Sig <= COL_OFF;
        end else begin
            Row_Scan_Sig    <= (SEG_ACT_LOW != 0) ? ~seg : seg;
            Column_Scan_Sig <= (SEL_ACT_LOW != 0) ? ~sel : sel;
        end
    end

endmodule

// File: tb/tb_smg_multi_digit_display.sv
// tb/tb_smg_multi_digit_display.sv - self-checking bench for smg_multi_digit_display
module tb_smg_multi_digit_display;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [19:0] data_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic        overflow;
    logic [7:0]  Row_Scan_Sig;
    logic [5:0]  Column_Scan_Sig;

    int total = 0;
    int bad = 0;

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    smg_multi_digit_display #(
        .DIGITS(6), .DATA_W(20), .SCAN_DIV(4), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .data_in(data_in), .load(load), .blank_lz(blank_lz),
        .busy(busy), .overflow(overflow), .Row_Scan_Sig(Row_Scan_Sig),
        .Column_Scan_Sig(Column_Scan_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected active-low pattern for digit k when value v is shown
    function automatic logic [7:0] exp_row(input int v, input int k, input bit bl);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v >= 1000000) return 8'hBF;
        if (bl && k > 0 && (v / p) == 0) return 8'hFF;
        return ~seg_tab[(v / p) % 10];
    endfunction

    task automatic do_load(input int v);
        @(negedge CLK);
        data_in = v[19:0];
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic check_display(input int v, input bit bl, input string tag);
        logic [5:0] seen = '0;
        logic [5:0] pat;
        int n = 0;
        repeat (2) @(negedge CLK);
        while (seen != 6'h3F && n < 60) begin
            for (int k = 0; k < 6; k++) begin
                pat = 6'h3F;
                pat[k] = 1'b0;
                if (Column_Scan_Sig === pat && !seen[k]) begin
                    chk($sformatf("%s_d%0d", tag, k), 32'(Row_Scan_Sig), 32'(exp_row(v, k, bl)));
                    seen[k] = 1'b1;
                end
            end
            n++;
            @(negedge CLK);
        end
        chk({tag, "_all_digits_seen"}, 32'(seen), 32'h3F);
    endtask

    task automatic convert(input int v, input bit bl, input string tag);
        int n;
        blank_lz = bl;
        do_load(v);
        wait_busy(n);
        chk({tag, "_busy_cycles"}, n, 21);
        chk({tag, "_overflow"}, 32'(overflow), (v >= 1000000) ? 1 : 0);
        check_display(v, bl, tag);
    endtask

    initial begin
        int n;
        int v;
        bit bl;
        logic [5:0] exp_col;

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_row", 32'(Row_Scan_Sig), 32'hFF);
        chk("rst_col", 32'(Column_Scan_Sig), 32'h3F);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // 1: scan sequence after release, each digit for 4 cycles, all showing 0
        RST_n = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            @(negedge CLK);
            exp_col = 6'h3F;
            exp_col[((c - 1) / 4) % 6] = 1'b0;
            chk($sformatf("scan_col_c%0d", c), 32'(Column_Scan_Sig), 32'(exp_col));
            chk($sformatf("scan_row_c%0d", c), 32'(Row_Scan_Sig), 32'hC0);
        end
        chk("idle_busy", 32'(busy), 0);

        // 2: 123456
        convert(123456, 1'b0, "v123456");

        // 3: 42 with blanking, then blanking released live
        convert(42, 1'b1, "v42_blank");
        blank_lz = 1'b0;
        check_display(42, 1'b0, "v42_noblank");

        // 4: overflow then recovery
        convert(1000000, 1'b0, "v1000000");
        convert(7, 1'b0, "v7");

        // 5: second load while busy is ignored
        do_load(555);
        repeat (4) @(negedge CLK);
        chk("busy_at_c5", 32'(busy), 1);
        data_in = 20'd999;
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
        wait_busy(n);
        chk("ignored_load_busy_tail", n, 16);
        check_display(555, 1'b0, "v555");

        // 6: asynchronous reset mid-conversion
        do_load(999999);
        repeat (9) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        chk("arst_row", 32'(Row_Scan_Sig), 32'hFF);
        chk("arst_col", 32'(Column_Scan_Sig), 32'h3F);
        chk("arst_busy", 32'(busy), 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_ovf", 32'(overflow), 0);
        check_display(0, 1'b0, "post_rst");

        // randomized values against the decimal reference model
        for (int r = 0; r < 8; r++) begin
            v = int'($urandom_range(0, 20'hFFFFF));
            if (r < 3) v = v % 1000;
            bl = 1'($urandom_range(0, 1));
            convert(v, bl, $sformatf("rand%0d_v%0d", r, v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
